opcode_encoder: RTL and testbench

Transmit-side counterpart of the casez opcode decoder. Accepts requests from three operand classes (A, B, C), arbitrates between them, and emits one 4-bit opcode per cycle over a valid/ready link. Each opcode's prefix matches the decoder's priority patterns: A = 1xxx, B = 01xx, C = 001x, idle = 0000. Sits between the request sources and the decoder; holds each class in a one-entry buffer and applies fixed priority with aging, so C and B cannot starve.

---
 rtl/opcode_pkg.sv | 11 +
 rtl/opcode_class_buf.sv | 33 +++
 rtl/opcode_encoder.sv | 96 +++++++++
 tb/tb_opcode_encoder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/opcode_pkg.sv
// Shared opcode encoding constants and enums for the opcode encoder slice.
package opcode_pkg;
  localparam int              OP_W     = 4;
  localparam logic            OP_A_PFX = 1'b1;
  localparam logic [1:0]      OP_B_PFX = 2'b01;
  localparam logic [2:0]      OP_C_PFX = 3'b001;
  localparam logic [OP_W-1:0] OP_IDLE  = 4'b0000;

  typedef enum logic {EMPTY, FULL} slot_state_e;
  typedef enum logic [1:0] {CLS_A, CLS_B, CLS_C} op_class_e;
endpackage

// File: rtl/opcode_class_buf.sv
// One-entry pending buffer; a grant frees the entry in the same cycle so a
// continuously-valid source can refill it at the edge that drains it.
module opcode_class_buf #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_grant,
  output logic         o_ready,
  output logic         o_pend,
  output logic [W-1:0] o_data
);
  logic         r_pend;
  logic [W-1:0] r_data;

  assign o_ready = !r_pend | i_grant;
  assign o_pend  = r_pend;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_data <= '0;
    end else if (i_valid && o_ready) begin
      r_pend <= 1'b1;
      r_data <= i_data;
    end else if (i_grant) begin
      r_pend <= 1'b0;
    end
  end
endmodule

// File: rtl/opcode_encoder.sv
// Three-class opcode encoder: fixed priority A > B > C with aging so a
// pending B or C is promoted after STARVE_LIMIT lost grants.
module opcode_encoder
  import opcode_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  input  logic [2:0]      a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [1:0]      b_data,
  output logic            b_ready,
  input  logic            c_valid,
  input  logic            c_data,
  output logic            c_ready,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [OP_W-1:0] opcode
);
  localparam int             CW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIM = CW'(STARVE_LIMIT);

  logic            w_a_pend, w_b_pend, w_c_pend;
  logic [2:0]      w_a_data;
  logic [1:0]      w_b_data;
  logic            w_c_data;
  logic            w_take, w_any;
  logic            w_grant_a, w_grant_b, w_grant_c;
  op_class_e       w_sel;
  slot_state_e     r_state;
  logic [OP_W-1:0] r_opcode;
  logic [CW-1:0]   r_cnt_b, r_cnt_c;

  opcode_class_buf #(.W(3)) u_buf_a (
    .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .i_data(a_data), .i_grant(w_grant_a),
    .o_ready(a_ready), .o_pend(w_a_pend), .o_data(w_a_data));
  opcode_class_buf #(.W(2)) u_buf_b (
    .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .i_data(b_data), .i_grant(w_grant_b),
    .o_ready(b_ready), .o_pend(w_b_pend), .o_data(w_b_data));
  opcode_class_buf #(.W(1)) u_buf_c (
    .clk(clk), .rst_n(rst_n), .i_valid(c_valid), .i_data(c_data), .i_grant(w_grant_c),
    .o_ready(c_ready), .o_pend(w_c_pend), .o_data(w_c_data));

  // Only registered pends compete, so same-cycle arrivals wait one edge.
  always_comb begin
    w_take = (r_state == EMPTY) | op_ready;
    w_any  = 1'b1;
    w_sel  = CLS_A;
    if (w_c_pend && r_cnt_c == LIM)      w_sel = CLS_C;
    else if (w_b_pend && r_cnt_b == LIM) w_sel = CLS_B;
    else if (w_a_pend)                   w_sel = CLS_A;
    else if (w_b_pend)                   w_sel = CLS_B;
    else if (w_c_pend)                   w_sel = CLS_C;
    else                                 w_any = 1'b0;
    w_grant_a = w_take && w_any && (w_sel == CLS_A);
    w_grant_b = w_take && w_any && (w_sel == CLS_B);
    w_grant_c = w_take && w_any && (w_sel == CLS_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_opcode <= OP_IDLE;
      r_cnt_b  <= '0;
      r_cnt_c  <= '0;
    end else begin
      if (w_take) begin
        if (w_any) begin
          r_state <= FULL;
          case (w_sel)
            CLS_B:   r_opcode <= {OP_B_PFX, w_b_data};
            CLS_C:   r_opcode <= {OP_C_PFX, w_c_data};
            default: r_opcode <= {OP_A_PFX, w_a_data};
          endcase
        end else begin
          r_state  <= EMPTY;
          r_opcode <= OP_IDLE;
        end
      end
      if (!w_b_pend || w_grant_b)
        r_cnt_b <= '0;
      else if ((w_grant_a || w_grant_c) && r_cnt_b != LIM)
        r_cnt_b <= r_cnt_b + 1'b1;
      if (!w_c_pend || w_grant_c)
        r_cnt_c <= '0;
      else if ((w_grant_a || w_grant_b) && r_cnt_c != LIM)
        r_cnt_c <= r_cnt_c + 1'b1;
    end
  end

  assign op_valid = (r_state == FULL);
  assign opcode   = r_opcode;
endmodule

// File: tb/tb_opcode_encoder.sv
// Directed bench for opcode_encoder: expected opcodes queued at stimulus
// time, popped whenever the DUT hands an opcode to the decoder.
module tb_opcode_encoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, c_valid;
  logic [2:0] a_data;
  logic [1:0] b_data;
  logic       c_data;
  logic       a_ready, b_ready, c_ready;
  logic       op_valid, op_ready;
  logic [3:0] opcode;

  logic [3:0] q[$];
  int checks = 0;
  int errors = 0;

  opcode_encoder #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
    .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic tick(input int ev);
    logic [3:0] e;
    @(negedge clk);
    if (ev >= 0) check("op_valid", 8'(op_valid), 8'(ev));
    if (op_valid === 1'b1) begin
      check("nonzero_opcode", 8'(opcode != 4'b0000), 8'd1);
      if (op_ready) begin
        if (q.size() == 0) begin
          check("unexpected_opcode", 8'(opcode), 8'hFF);
        end else begin
          e = q.pop_front();
          check("opcode", 8'(opcode), 8'(e));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with requests presented: all must be discarded.
    rst_n = 1'b0; op_ready = 1'b1;
    a_valid = 1'b1; a_data = 3'b111;
    b_valid = 1'b1; b_data = 2'b11;
    c_valid = 1'b1; c_data = 1'b1;
    tick(0);
    tick(0);
    check("rst_opcode", 8'(opcode), 8'h0);
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    tick(0);
    rst_n = 1'b1;
    check("rst_ready", {5'd0, a_ready, b_ready, c_ready}, 8'h07);
    tick(0); tick(0); tick(0);

    // Single A: accepted at first edge, visible for exactly one cycle.
    a_valid = 1'b1; a_data = 3'b011; q.push_back(4'b1011);
    tick(0);
    a_valid = 1'b0;
    tick(0);
    tick(1);
    tick(0);
    check("idle_opcode", 8'(opcode), 8'h0);

    // Three-way contention resolves A, B, C on consecutive cycles.
    a_valid = 1'b1; a_data = 3'b101; q.push_back(4'b1101);
    b_valid = 1'b1; b_data = 2'b10; q.push_back(4'b0110);
    c_valid = 1'b1; c_data = 1'b0;  q.push_back(4'b0010);
    tick(0);
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    tick(0);
    tick(1); tick(1); tick(1);
    tick(0);

    // Backpressure: slot holds 0101 while a second B waits in its buffer.
    op_ready = 1'b0;
    b_valid = 1'b1; b_data = 2'b01; q.push_back(4'b0101);
    tick(0);
    b_data = 2'b10; q.push_back(4'b0110);
    tick(0);
    b_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_opcode", 8'(opcode), 8'h05);
      check("bp_b_ready", 8'(b_ready), 8'h00);
    end
    op_ready = 1'b1;
    tick(1);
    tick(1);
    tick(0);

    // Starvation: C promoted after exactly four A grants.
    a_valid = 1'b1; a_data = 3'b010;
    c_valid = 1'b1; c_data = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(4'b1010);
    q.push_back(4'b0011);
    for (int i = 0; i < 3; i++) q.push_back(4'b1010);
    tick(0);
    c_valid = 1'b0;
    tick(0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (i == 2) check("cnt_c_sat", 8'(dut.r_cnt_c), 8'd4);
      if (i == 3) check("cnt_c_clr", 8'(dut.r_cnt_c), 8'd0);
    end
    a_valid = 1'b0;
    tick(1);
    tick(1);
    tick(0);

    // Mid-operation reset: FULL slot and pending B are both dropped.
    op_ready = 1'b0;
    a_valid = 1'b1; a_data = 3'b111;
    b_valid = 1'b1; b_data = 2'b11;
    tick(0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick(0);
    check("mr_full", {3'd0, op_valid, opcode}, 8'h1F);
    rst_n = 1'b0;
    #1;
    check("mr_drop", {3'd0, op_valid, opcode}, 8'h00);
    check("mr_ready", {5'd0, a_ready, b_ready, c_ready}, 8'h07);
    tick(0);
    rst_n = 1'b1; op_ready = 1'b1;
    tick(0); tick(0); tick(0); tick(0);

    check("sb_empty", 8'(q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
